// File: rtl/udma_sdio_cmd_seq.sv
// SDIO command sequencer: takes one descriptor, clears status, starts sdio_txrx,
// waits for eot or timeout, retries cmd/data errors, then reports one completion.
module udma_sdio_cmd_seq #(
  parameter int unsigned TIMEOUT_W = 24,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [5:0]           req_op_i,
  input  logic [31:0]          req_arg_i,
  input  logic [2:0]           req_rsp_type_i,
  input  logic                 req_data_en_i,
  input  logic                 req_data_rwn_i,
  input  logic                 req_data_quad_i,
  input  logic [9:0]           req_blk_size_i,
  input  logic [7:0]           req_blk_num_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic                 cmd_start_o,
  output logic [5:0]           cmd_op_o,
  output logic [31:0]          cmd_arg_o,
  output logic [2:0]           cmd_rsp_type_o,
  output logic                 data_en_o,
  output logic                 data_rwn_o,
  output logic                 data_quad_o,
  output logic [9:0]           data_blk_size_o,
  output logic [7:0]           data_blk_num_o,
  output logic                 clr_stat_o,
  input  logic                 eot_i,
  input  logic [15:0]          status_i,
  output logic                 done_o,
  output logic [2:0]           err_o,
  output logic [15:0]          last_status_o,
  output logic [1:0]           retry_cnt_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_START, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t               state, state_n;
  logic [TIMEOUT_W-1:0] timer, timer_n;
  logic [1:0]           retry_n;
  logic [2:0]           err_n;
  logic [15:0]          status_n;
  logic                 accept;
  logic                 cmd_err, data_err;

  assign cmd_err  = |status_i[5:0];
  assign data_err = |status_i[13:8];

  // Next-state, timer, retry and error bookkeeping
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    retry_n  = retry_cnt_o;
    err_n    = err_o;
    status_n = last_status_o;
    accept   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          retry_n = 2'd0;
          err_n   = 3'd0;
          state_n = S_CLR;
        end
      end
      S_CLR:   state_n = S_START;
      S_START: begin
        timer_n = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (timer != '1) timer_n = timer + TIMEOUT_W'(1);
        // eot has priority over a timeout landing in the same cycle
        if (eot_i) begin
          state_n = S_CHECK;
        end else if ((timeout_i != '0) && (timer == timeout_i - TIMEOUT_W'(1))) begin
          err_n   = 3'b100;
          state_n = S_DONE;
        end
      end
      S_CHECK: begin
        status_n = status_i;
        if (cmd_err || data_err) begin
          if (32'(retry_cnt_o) < MAX_RETRY) begin
            retry_n = (retry_cnt_o == 2'b11) ? retry_cnt_o : retry_cnt_o + 2'd1;
            state_n = S_CLR;
          end else begin
            err_n   = {1'b0, data_err, cmd_err};
            state_n = S_DONE;
          end
        end else begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State, registered pulses and latched descriptor
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state           <= S_IDLE;
      timer           <= '0;
      retry_cnt_o     <= 2'd0;
      err_o           <= 3'd0;
      last_status_o   <= 16'd0;
      clr_stat_o      <= 1'b0;
      cmd_start_o     <= 1'b0;
      done_o          <= 1'b0;
      req_ready_o     <= 1'b1;
      busy_o          <= 1'b0;
      cmd_op_o        <= 6'd0;
      cmd_arg_o       <= 32'd0;
      cmd_rsp_type_o  <= 3'd0;
      data_en_o       <= 1'b0;
      data_rwn_o      <= 1'b0;
      data_quad_o     <= 1'b0;
      data_blk_size_o <= 10'd0;
      data_blk_num_o  <= 8'd0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      retry_cnt_o   <= retry_n;
      err_o         <= err_n;
      last_status_o <= status_n;
      clr_stat_o    <= (state_n == S_CLR);
      cmd_start_o   <= (state_n == S_START);
      done_o        <= (state_n == S_DONE);
      req_ready_o   <= (state_n == S_IDLE);
      busy_o        <= (state_n != S_IDLE);
      if (accept) begin
        cmd_op_o        <= req_op_i;
        cmd_arg_o       <= req_arg_i;
        cmd_rsp_type_o  <= req_rsp_type_i;
        data_en_o       <= req_data_en_i;
        data_rwn_o      <= req_data_rwn_i;
        data_quad_o     <= req_data_quad_i;
        data_blk_size_o <= req_blk_size_i;
        data_blk_num_o  <= req_blk_num_i;
      end else if (state_n == S_IDLE) begin
        data_en_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_udma_sdio_cmd_seq.sv
// Bench for udma_sdio_cmd_seq: directed scenarios plus randomized descriptors and
// per-attempt card responses, checked against an attempt-level timing model.
module tb_udma_sdio_cmd_seq;
  localparam int TW = 24;
  localparam int MAX_RETRY = 2;

  logic clk = 1'b0;
  logic rstn;
  logic req_valid, req_ready;
  logic [5:0] req_op;
  logic [31:0] req_arg;
  logic [2:0] req_rsp_type;
  logic req_data_en, req_data_rwn, req_data_quad;
  logic [9:0] req_blk_size;
  logic [7:0] req_blk_num;
  logic [TW-1:0] timeout;
  logic cmd_start, clr_stat, eot, done, busy;
  logic [5:0] cmd_op;
  logic [31:0] cmd_arg;
  logic [2:0] cmd_rsp_type, err;
  logic data_en, data_rwn, data_quad;
  logic [9:0] data_blk_size;
  logic [7:0] data_blk_num;
  logic [15:0] status, last_status;
  logic [1:0] retry_cnt;

  udma_sdio_cmd_seq #(.TIMEOUT_W(TW), .MAX_RETRY(MAX_RETRY)) dut (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_arg_i(req_arg), .req_rsp_type_i(req_rsp_type),
    .req_data_en_i(req_data_en), .req_data_rwn_i(req_data_rwn),
    .req_data_quad_i(req_data_quad), .req_blk_size_i(req_blk_size),
    .req_blk_num_i(req_blk_num), .timeout_i(timeout), .cmd_start_o(cmd_start),
    .cmd_op_o(cmd_op), .cmd_arg_o(cmd_arg), .cmd_rsp_type_o(cmd_rsp_type),
    .data_en_o(data_en), .data_rwn_o(data_rwn), .data_quad_o(data_quad),
    .data_blk_size_o(data_blk_size), .data_blk_num_o(data_blk_num),
    .clr_stat_o(clr_stat), .eot_i(eot), .status_i(status), .done_o(done),
    .err_o(err), .last_status_o(last_status), .retry_cnt_o(retry_cnt), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Per-attempt card behaviour: eot delay after WAIT entry (-1 = never) and status
  int att_j[0:3];
  logic [15:0] att_s[0:3];

  // Observations of one transaction
  int acc, obs_done;
  int obs_starts[$];
  int obs_clrs[$];
  logic obs_ready_acc, obs_den, obs_ready_after, obs_den_after, obs_done_after;
  logic [2:0] obs_err;
  logic [1:0] obs_retry;
  logic [15:0] obs_stat;
  logic [60:0] obs_fields, exp_fields;

  // Model expectations
  int exp_starts[$];
  int exp_done, exp_retry;
  logic [2:0] exp_err;
  logic [15:0] exp_stat;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Attempt-level model: each attempt is clr, start, then WAIT starting one cycle later
  task automatic model(input int accept_cyc, input int to);
    int w, k, j, e;
    logic ce, de;
    exp_starts.delete();
    w = accept_cyc + 3;
    k = 0;
    forever begin
      exp_starts.push_back(w - 1);
      j = att_j[k];
      if (j >= 0 && (to == 0 || j < to)) begin
        e = w + j;
        ce = |att_s[k][5:0];
        de = |att_s[k][13:8];
        exp_stat = att_s[k];
        if ((ce || de) && k < MAX_RETRY) begin
          k++;
          w = e + 4;
        end else begin
          exp_err = {1'b0, de, ce};
          exp_done = e + 2;
          exp_retry = k;
          break;
        end
      end else begin
        exp_err = 3'b100;
        exp_done = w + to;
        exp_retry = k;
        break;
      end
    end
  endtask

  task automatic run_txn(input logic [5:0] op, input logic [31:0] arg, input logic [2:0] rsp,
                         input logic den, input logic rwn, input logic quad,
                         input logic [9:0] bsz, input logic [7:0] bnum, input int to);
    int eot_at, k;
    obs_starts.delete();
    obs_clrs.delete();
    obs_done = -1;
    eot_at = -1;
    step();
    acc = cyc;
    obs_ready_acc = req_ready;
    req_valid = 1'b1; req_op = op; req_arg = arg; req_rsp_type = rsp;
    req_data_en = den; req_data_rwn = rwn; req_data_quad = quad;
    req_blk_size = bsz; req_blk_num = bnum; timeout = TW'(to);
    exp_fields = {op, arg, rsp, rwn, quad, bsz, bnum};
    for (int n = 0; n < 600 && obs_done < 0; n++) begin
      step();
      req_valid = 1'b0;
      eot = 1'b0;
      if (cyc == eot_at) eot = 1'b1;
      if (clr_stat) obs_clrs.push_back(cyc);
      if (cmd_start) begin
        k = obs_starts.size();
        obs_starts.push_back(cyc);
        if (k < 4) begin
          status = att_s[k];
          eot_at = (att_j[k] >= 0) ? cyc + 1 + att_j[k] : -1;
        end
      end
      if (done) begin
        obs_done = cyc;
        obs_err = err;
        obs_retry = retry_cnt;
        obs_stat = last_status;
        obs_den = data_en;
        obs_fields = {cmd_op, cmd_arg, cmd_rsp_type, data_rwn, data_quad, data_blk_size, data_blk_num};
      end
    end
    step();
    eot = 1'b0;
    obs_ready_after = req_ready;
    obs_den_after = data_en;
    obs_done_after = done;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req_valid = 1'b0; req_op = '0; req_arg = '0; req_rsp_type = '0;
    req_data_en = 1'b0; req_data_rwn = 1'b0; req_data_quad = 1'b0;
    req_blk_size = '0; req_blk_num = '0; timeout = '0; eot = 1'b0; status = '0;
    repeat (3) step();
    vectors++;
    if ({req_ready, busy, cmd_start, clr_stat, done} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 10000", {req_ready, busy, cmd_start, clr_stat, done});
    end
    vectors++;
    if ({cmd_op, cmd_arg, cmd_rsp_type, data_en, data_rwn, data_quad, data_blk_size,
         data_blk_num, err, last_status, retry_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_fields: nonzero latched/status outputs");
    end
    rstn = 1'b1;
  endtask

  task automatic test_single_cmd();
    att_j[0] = 9; att_s[0] = 16'h0000;
    run_txn(6'd17, 32'h200, 3'd1, 1'b0, 1'b1, 1'b0, 10'd0, 8'd0, 0);
    vectors++;
    if (obs_starts.size() != 1 || obs_starts[0] != acc + 2) begin
      miscompares++;
      $display("FAIL single_start: got n=%0d first=%0d want 1 at %0d", obs_starts.size(),
               (obs_starts.size() > 0) ? obs_starts[0] - acc : -1, 2);
    end
    vectors++;
    if (obs_done != acc + 14) begin
      miscompares++;
      $display("FAIL single_done: got %0d want %0d", obs_done - acc, 14);
    end
    vectors++;
    if ({obs_err, obs_retry} !== 5'b00000) begin
      miscompares++;
      $display("FAIL single_err: got err=%b retry=%0d want 000/0", obs_err, obs_retry);
    end
    vectors++;
    if (obs_fields !== exp_fields || obs_ready_after !== 1'b1) begin
      miscompares++;
      $display("FAIL single_fields: got %h ready=%b want %h ready=1", obs_fields, obs_ready_after, exp_fields);
    end
  endtask

  task automatic test_retry_exhaust();
    for (int i = 0; i < 4; i++) begin att_j[i] = 5; att_s[i] = 16'h0100; end
    run_txn(6'd25, 32'h1234, 3'd1, 1'b1, 1'b0, 1'b1, 10'd512, 8'd3, 0);
    model(acc, 0);
    vectors++;
    if (obs_starts.size() != 3 || obs_clrs.size() != 3) begin
      miscompares++;
      $display("FAIL exhaust_count: got starts=%0d clrs=%0d want 3/3", obs_starts.size(), obs_clrs.size());
    end
    for (int i = 0; i < 3 && i < obs_starts.size() && i < obs_clrs.size(); i++) begin
      vectors++;
      if (obs_starts[i] != exp_starts[i] || obs_clrs[i] != exp_starts[i] - 1) begin
        miscompares++;
        $display("FAIL exhaust_seq%0d: got clr=%0d start=%0d want %0d/%0d", i,
                 obs_clrs[i] - acc, obs_starts[i] - acc, exp_starts[i] - 1 - acc, exp_starts[i] - acc);
      end
    end
    vectors++;
    if (obs_err !== 3'b010 || obs_retry !== 2'd2 || obs_done != exp_done || obs_den !== 1'b1) begin
      miscompares++;
      $display("FAIL exhaust_result: got err=%b retry=%0d done=%0d den=%b want 010/2/%0d/1",
               obs_err, obs_retry, obs_done - acc, obs_den, exp_done - acc);
    end
    vectors++;
    if (obs_den_after !== 1'b0 || obs_done_after !== 1'b0 || data_blk_num !== 8'd3) begin
      miscompares++;
      $display("FAIL exhaust_idle: got den=%b done=%b bnum=%0d want 0/0/3", obs_den_after, obs_done_after, data_blk_num);
    end
  endtask

  task automatic test_retry_recover();
    att_j[0] = 3; att_s[0] = 16'h0001;
    att_j[1] = 7; att_s[1] = 16'h0000;
    run_txn(6'd52, 32'hdead_beef, 3'd2, 1'b0, 1'b0, 1'b0, 10'd4, 8'd0, 0);
    model(acc, 0);
    vectors++;
    if (obs_starts.size() != 2 || obs_err !== 3'b000 || obs_retry !== 2'd1) begin
      miscompares++;
      $display("FAIL recover: got starts=%0d err=%b retry=%0d want 2/000/1", obs_starts.size(), obs_err, obs_retry);
    end
    vectors++;
    if (obs_done != exp_done || obs_stat !== 16'h0000) begin
      miscompares++;
      $display("FAIL recover_done: got %0d stat=%h want %0d stat=0000", obs_done - acc, obs_stat, exp_done - acc);
    end
  endtask

  task automatic test_timeout();
    att_j[0] = -1; att_s[0] = 16'h0000;
    run_txn(6'd18, 32'h0, 3'd1, 1'b1, 1'b1, 1'b1, 10'd64, 8'd1, 50);
    vectors++;
    if (obs_done != acc + 53 || obs_err !== 3'b100 || obs_starts.size() != 1 || obs_retry !== 2'd0) begin
      miscompares++;
      $display("FAIL timeout: got done=%0d err=%b starts=%0d retry=%0d want 53/100/1/0",
               obs_done - acc, obs_err, obs_starts.size(), obs_retry);
    end
    att_j[0] = 49; att_s[0] = 16'h0000;
    run_txn(6'd18, 32'h1, 3'd1, 1'b0, 1'b1, 1'b0, 10'd64, 8'd0, 50);
    vectors++;
    if (obs_done != acc + 54 || obs_err !== 3'b000) begin
      miscompares++;
      $display("FAIL timeout_tie: got done=%0d err=%b want 54/000", obs_done - acc, obs_err);
    end
  endtask

  task automatic test_reset_mid();
    int r;
    bit seen;
    step();
    timeout = TW'(6);
    req_valid = 1'b1; req_op = 6'd9; req_arg = 32'h55; req_data_en = 1'b1;
    repeat (4) step();
    rstn = 1'b0;
    #1;
    vectors++;
    if ({req_ready, busy, clr_stat, cmd_start, done, data_en, cmd_op, err} !== {1'b1, 14'b0}) begin
      miscompares++;
      $display("FAIL reset_mid: got ready=%b busy=%b den=%b op=%0d want 1/0/0/0", req_ready, busy, data_en, cmd_op);
    end
    seen = 0;
    repeat (2) begin step(); if (done) seen = 1; end
    rstn = 1'b1;
    r = cyc;
    step();
    vectors++;
    if (clr_stat !== 1'b1 || seen) begin
      miscompares++;
      $display("FAIL reset_reaccept: got clr=%b at +%0d done_seen=%0d want clr=1 done_seen=0", clr_stat, cyc - r, seen);
    end
    req_valid = 1'b0;
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin step(); if (done) seen = 1; end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL reset_finish: got no done within 50 cycles want done");
    end
    step();
    eot = 1'b1;
    step();
    eot = 1'b0;
    seen = 0;
    repeat (5) begin step(); if (clr_stat || cmd_start || done || !req_ready) seen = 1; end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL idle_eot: got activity after eot in IDLE want none");
    end
  endtask

  task automatic test_random();
    int to, etype;
    logic [15:0] s;
    for (int t = 0; t < 40; t++) begin
      to = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(3, 40));
      for (int a = 0; a < 4; a++) begin
        if (to == 0) att_j[a] = int'($urandom_range(0, 30));
        else case ($urandom_range(0, 3))
          0: att_j[a] = -1;
          1: att_j[a] = to - 1;
          2: att_j[a] = to;
          default: att_j[a] = int'($urandom_range(0, to + 3));
        endcase
        etype = int'($urandom_range(0, 3));
        s = 16'($urandom) & 16'hC0C0;
        if (etype[0]) s[$urandom_range(0, 5)] = 1'b1;
        if (etype[1]) s[8 + $urandom_range(0, 5)] = 1'b1;
        att_s[a] = s;
      end
      run_txn(6'($urandom), $urandom, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              10'($urandom), 8'($urandom), to);
      model(acc, to);
      vectors++;
      if (obs_ready_acc !== 1'b1 || obs_starts.size() != exp_starts.size() || obs_clrs.size() != exp_starts.size()) begin
        miscompares++;
        $display("FAIL rnd%0d_count: got ready=%b starts=%0d clrs=%0d want 1/%0d/%0d", t, obs_ready_acc,
                 obs_starts.size(), obs_clrs.size(), exp_starts.size(), exp_starts.size());
      end else begin
        for (int i = 0; i < exp_starts.size(); i++) begin
          vectors++;
          if (obs_starts[i] != exp_starts[i] || obs_clrs[i] != exp_starts[i] - 1) begin
            miscompares++;
            $display("FAIL rnd%0d_seq%0d: got clr=%0d start=%0d want %0d/%0d", t, i,
                     obs_clrs[i] - acc, obs_starts[i] - acc, exp_starts[i] - 1 - acc, exp_starts[i] - acc);
          end
        end
      end
      vectors++;
      if (obs_done != exp_done || obs_err !== exp_err || obs_retry !== 2'(exp_retry)) begin
        miscompares++;
        $display("FAIL rnd%0d_result: got done=%0d err=%b retry=%0d want %0d/%b/%0d", t,
                 obs_done - acc, obs_err, obs_retry, exp_done - acc, exp_err, exp_retry);
      end
      if (!exp_err[2]) begin
        vectors++;
        if (obs_stat !== exp_stat) begin
          miscompares++;
          $display("FAIL rnd%0d_status: got %h want %h", t, obs_stat, exp_stat);
        end
      end
      vectors++;
      if (obs_fields !== exp_fields || obs_den !== req_data_en || obs_den_after !== 1'b0 ||
          obs_ready_after !== 1'b1 || obs_done_after !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd%0d_fields: got %h den=%b/%b ready=%b done=%b want %h den=%b/0 ready=1 done=0", t,
                 obs_fields, obs_den, obs_den_after, obs_ready_after, obs_done_after, exp_fields, req_data_en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_cmd();
    test_retry_exhaust();
    test_retry_recover();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
